sample_loss_monitor: RTL and testbench

- Slow-domain consumer placed directly downstream of data_sampler; receives its valid_o/data_o stream on slow_clk.
- Treats the low SEQ_W bits of each sample as a sequence number and counts samples captured vs. samples lost in the fast-to-slow crossing.
- Flags duplicate and backwards samples.
- Forwards every sample with one cycle of latency, tagged with its gap, so later stages can use the data and the loss statistics together.

---
 rtl/sample_loss_pkg.sv | 20 ++
 rtl/sample_loss_monitor_sat_counter.sv | 29 ++
 rtl/sample_loss_monitor.sv | 131 +++++++++++++
 tb/tb_sample_loss_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_loss_pkg.sv
// Shared types and constants for the sample loss monitor.
package sample_loss_pkg;

  typedef enum logic {IDLE, TRACK} state_e;

  typedef enum logic [1:0] {OK, DUP, BACK} cls_e;

  localparam int HIST_BINS = 4;
  // Lower gap bound of bins 1, 2 and 3; bin0 holds gap 0.
  localparam int BIN1_LO   = 1;
  localparam int BIN2_LO   = 2;
  localparam int BIN3_LO   = 4;

  function automatic cls_e classify(input logic zero_delta, input logic back_half);
    if (zero_delta) return DUP;
    if (back_half)  return BACK;
    return OK;
  endfunction

endpackage

// File: rtl/sample_loss_monitor_sat_counter.sv
// Saturating accumulator: adds inc_i + add_i per cycle, clr_i zeroes the old value first.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d, base;
  logic [W+1:0] sum;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    sum   = {2'b00, base} + {2'b00, add_i} + (W+2)'(inc_i);
    cnt_d = (|sum[W+1:W]) ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sample_loss_monitor.sv
// Sequence-number loss monitor for the slow side of data_sampler; forwards samples with their gap.
// Optional gap histogram built when SAMPLE_LOSS_HIST_EN is defined, otherwise hist_o is 0.
import sample_loss_pkg::*;

module sample_loss_monitor #(
  parameter int DATA_W = 64,
  parameter int SEQ_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 slow_clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 valid_i,
  output logic [DATA_W-1:0]    data_o,
  output logic                 valid_o,
  output logic [SEQ_W-1:0]     gap_o,
  output logic [CNT_W-1:0]     captured_cnt_o,
  output logic [CNT_W-1:0]     dropped_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [SEQ_W-1:0]     max_gap_o,
  output logic                 err_o,
  output logic                 tracking_o,
  output logic [4*CNT_W-1:0]   hist_o
);

  localparam int WW = (SEQ_W > CNT_W) ? SEQ_W : CNT_W;

  state_e              state_q, eff_state;
  cls_e                cls;
  logic [SEQ_W-1:0]    seq, delta, gap, last_seq_q, gap_q, max_gap_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q, err_q;
  logic                first_s, track_s, good_s, err_s;
  logic [WW-1:0]       gap_w;
  logic [CNT_W-1:0]    drop_add;

  // clear_i in the same cycle as a sample makes that sample an IDLE first sample.
  always_comb begin
    seq       = data_i[SEQ_W-1:0];
    eff_state = clear_i ? IDLE : state_q;
    delta     = seq - last_seq_q;
    cls       = classify(delta == '0, delta[SEQ_W-1]);
    first_s   = valid_i && (eff_state == IDLE);
    track_s   = valid_i && (eff_state == TRACK);
    good_s    = track_s && (cls == OK);
    err_s     = track_s && (cls != OK);
    gap       = good_s ? (delta - SEQ_W'(1)) : '0;
  end

  assign gap_w    = WW'(gap);
  assign drop_add = (gap_w > WW'({CNT_W{1'b1}})) ? '1 : CNT_W'(gap_w);

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_seq_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      gap_q      <= '0;
      max_gap_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
        gap_q  <= gap;
      end
      if (clear_i) begin
        state_q   <= IDLE;
        max_gap_q <= '0;
        err_q     <= 1'b0;
      end
      if (good_s && (gap > max_gap_q)) max_gap_q <= gap;
      if (err_s)   err_q      <= 1'b1;
      if (valid_i) state_q    <= TRACK;
      if (first_s || good_s) last_seq_q <= seq;
    end
  end

  sat_counter #(.W(CNT_W)) u_cap (
    .clk_i(slow_clk), .rst_ni(rst), .clr_i(clear_i),
    .inc_i(valid_i), .add_i('0), .cnt_o(captured_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_drop (
    .clk_i(slow_clk), .rst_ni(rst), .clr_i(clear_i),
    .inc_i(1'b0), .add_i(drop_add), .cnt_o(dropped_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_err (
    .clk_i(slow_clk), .rst_ni(rst), .clr_i(clear_i),
    .inc_i(err_s), .add_i('0), .cnt_o(err_cnt_o)
  );

`ifdef SAMPLE_LOSS_HIST_EN
  localparam int GW = (SEQ_W > 32) ? SEQ_W : 32;

  logic [GW-1:0]        gap_g;
  logic [HIST_BINS-1:0] bin_hit;

  assign gap_g = GW'(gap);

  always_comb begin
    bin_hit = '0;
    if (good_s) begin
      if      (gap_g < GW'(BIN1_LO)) bin_hit[0] = 1'b1;
      else if (gap_g < GW'(BIN2_LO)) bin_hit[1] = 1'b1;
      else if (gap_g < GW'(BIN3_LO)) bin_hit[2] = 1'b1;
      else                           bin_hit[3] = 1'b1;
    end
  end

  for (genvar b = 0; b < HIST_BINS; b++) begin : g_bin
    sat_counter #(.W(CNT_W)) u_bin (
      .clk_i(slow_clk), .rst_ni(rst), .clr_i(clear_i),
      .inc_i(bin_hit[b]), .add_i('0), .cnt_o(hist_o[b*CNT_W +: CNT_W])
    );
  end
`else
  assign hist_o = '0;
`endif

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign gap_o      = gap_q;
  assign max_gap_o  = max_gap_q;
  assign err_o      = err_q;
  assign tracking_o = (state_q == TRACK);

endmodule

// File: tb/tb_sample_loss_monitor.sv
// Scoreboard bench for sample_loss_monitor: forwarded samples checked against a queue, stats per scenario.
module tb_sample_loss_monitor;

  localparam int DW = 64;
  localparam int SW = 16;
  localparam int CW = 32;

  logic            slow_clk = 1'b0;
  logic            rst = 1'b0;
  logic            clear_i = 1'b0;
  logic            valid_i = 1'b0;
  logic [DW-1:0]   data_i;
  logic [DW-1:0]   data_o;
  logic            valid_o;
  logic [SW-1:0]   gap_o;
  logic [CW-1:0]   captured_cnt_o, dropped_cnt_o, err_cnt_o;
  logic [SW-1:0]   max_gap_o;
  logic            err_o, tracking_o;
  logic [4*CW-1:0] hist_o;

  sample_loss_monitor #(.DATA_W(DW), .SEQ_W(SW), .CNT_W(CW)) dut (
    .slow_clk(slow_clk), .rst(rst), .clear_i(clear_i), .data_i(data_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .gap_o(gap_o),
    .captured_cnt_o(captured_cnt_o), .dropped_cnt_o(dropped_cnt_o), .err_cnt_o(err_cnt_o),
    .max_gap_o(max_gap_o), .err_o(err_o), .tracking_o(tracking_o), .hist_o(hist_o)
  );

  always #5 slow_clk = ~slow_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] gap;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic          vld_d;
  logic [DW-1:0] last_data;

  // Expected valid_o: the valid_i seen at the previous edge.
  always @(posedge slow_clk or negedge rst) begin
    if (!rst) vld_d <= 1'b0;
    else      vld_d <= valid_i;
  end

  always @(negedge slow_clk) begin
    exp_t e;
    checks++;
    if (valid_o !== vld_d) begin
      errors++;
      $display("FAIL valid_latency: valid_o=%b expected %b at %0t", valid_o, vld_d, $time);
    end
    checks++;
    if ($isunknown({data_o, valid_o, gap_o, captured_cnt_o, dropped_cnt_o, err_cnt_o,
                    max_gap_o, err_o, tracking_o, hist_o})) begin
      errors++;
      $display("FAIL x_on_output: unknown bits on an output at %0t", $time);
    end
    if (valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: data_o=%h with empty scoreboard", data_o);
      end else begin
        e = sb.pop_front();
        if (data_o !== e.data || gap_o !== e.gap) begin
          errors++;
          $display("FAIL forward: data_o=%h gap_o=%0d expected data=%h gap=%0d",
                   data_o, gap_o, e.data, e.gap);
        end
      end
    end
  end

  task automatic send(input logic [SW-1:0] seq, input logic [SW-1:0] g);
    exp_t          e;
    logic [DW-1:0] d;
    d          = {$urandom, $urandom};
    d[SW-1:0]  = seq;
    e.data     = d;
    e.gap      = g;
    sb.push_back(e);
    last_data  = d;
    data_i     = d;
    valid_i    = 1'b1;
    @(posedge slow_clk); #1;
    valid_i    = 1'b0;
    data_i     = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge slow_clk); #1; end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge slow_clk); #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = 'x;
    idle(3);
    checks++;
    if ({valid_o, data_o, gap_o, captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o,
         err_o, tracking_o, hist_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: cap=%0d drop=%0d err=%0d max=%0d err_o=%b trk=%b vo=%b data=%h expected all 0",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o, tracking_o, valid_o, data_o);
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    send(1, 0); send(2, 0); send(3, 0);
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, err_o, tracking_o} !==
        {32'd3, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_stats: cap=%0d drop=%0d err=%0d err_o=%b trk=%b expected 3 0 0 0 1",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, err_o, tracking_o);
    end
    idle(2);
  endtask

  task automatic test_gaps();
    logic [4*CW-1:0] exp_hist;
    do_clear();
    send(1, 0); send(2, 0); send(5, 2); send(6, 0); send(10, 3);
`ifdef SAMPLE_LOSS_HIST_EN
    exp_hist = {32'd0, 32'd2, 32'd0, 32'd2};
`else
    exp_hist = '0;
`endif
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o} !==
        {32'd5, 32'd5, 32'd0, 16'd3, 1'b0}) begin
      errors++;
      $display("FAIL gap_stats: cap=%0d drop=%0d err=%0d max=%0d err_o=%b expected 5 5 0 3 0",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o);
    end
    checks++;
    if (hist_o !== exp_hist) begin
      errors++;
      $display("FAIL gap_hist: hist_o=%h expected %h", hist_o, exp_hist);
    end
    idle(2);
  endtask

  task automatic test_wrap();
    do_clear();
    send(16'hFFFE, 0); send(16'hFFFF, 0); send(16'h0000, 0); send(16'h0002, 1);
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o} !==
        {32'd4, 32'd1, 32'd0, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_stats: cap=%0d drop=%0d err=%0d max=%0d err_o=%b expected 4 1 0 1 0",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o);
    end
    idle(2);
  endtask

  task automatic test_errors();
    do_clear();
    send(4, 0); send(4, 0); send(3, 0); send(7, 2);
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o, tracking_o} !==
        {32'd4, 32'd2, 32'd2, 16'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL err_stats: cap=%0d drop=%0d err=%0d max=%0d err_o=%b trk=%b expected 4 2 2 2 1 1",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o, tracking_o);
    end
    send(8, 0);
    idle(2);
    checks++;
    if ({err_o, err_cnt_o, captured_cnt_o} !== {1'b1, 32'd2, 32'd5}) begin
      errors++;
      $display("FAIL err_sticky: err_o=%b err=%0d cap=%0d expected 1 2 5", err_o, err_cnt_o, captured_cnt_o);
    end
  endtask

  // Continues from test_errors so the clear also has a sticky error to drop.
  task automatic test_clear();
    clear_i = 1'b1;
    send(9, 0);
    clear_i = 1'b0;
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o, tracking_o, hist_o} !==
        {32'd1, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1, 128'd0}) begin
      errors++;
      $display("FAIL clear_with_valid: cap=%0d drop=%0d err=%0d max=%0d err_o=%b trk=%b expected 1 0 0 0 0 1",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, err_o, tracking_o);
    end
    send(10, 0);
    checks++;
    if ({captured_cnt_o, dropped_cnt_o} !== {32'd2, 32'd0}) begin
      errors++;
      $display("FAIL clear_next: cap=%0d drop=%0d expected 2 0", captured_cnt_o, dropped_cnt_o);
    end
    send(11, 0);
    do_clear();
    checks++;
    if ({captured_cnt_o, tracking_o} !== {32'd0, 1'b0}) begin
      errors++;
      $display("FAIL clear_plain: cap=%0d trk=%b expected 0 0", captured_cnt_o, tracking_o);
    end
    idle(2);
  endtask

  task automatic test_x_idle();
    logic [SW-1:0] s;
    int            step, g, drop, mx;
    do_clear();
    s = 16'd100; drop = 0; mx = 0;
    for (int i = 0; i < 20; i++) begin
      step = $urandom_range(1, 3);
      if (i > 0) s = s + SW'(step);
      g = (i == 0) ? 0 : step - 1;
      drop += g;
      if (g > mx) mx = g;
      send(s, SW'(g));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        idle(1);
        checks++;
        if (data_o !== last_data) begin
          errors++;
          $display("FAIL data_hold: data_o=%h expected %h", data_o, last_data);
        end
      end
    end
    checks++;
    if ({captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o} !==
        {32'd20, CW'(drop), 32'd0, SW'(mx)}) begin
      errors++;
      $display("FAIL x_idle_stats: cap=%0d drop=%0d err=%0d max=%0d expected 20 %0d 0 %0d",
               captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o, drop, mx);
    end
    idle(2);
  endtask

  task automatic test_rst_mid();
    do_clear();
    send(5, 0); send(6, 0);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, data_o, gap_o, captured_cnt_o, dropped_cnt_o, err_cnt_o, max_gap_o,
         err_o, tracking_o, hist_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid: vo=%b data=%h cap=%0d trk=%b expected all 0",
               valid_o, data_o, captured_cnt_o, tracking_o);
    end
    sb.delete();
    idle(1);
    rst = 1'b1;
    idle(1);
    send(7, 0);
    checks++;
    if ({captured_cnt_o, tracking_o} !== {32'd1, 1'b1}) begin
      errors++;
      $display("FAIL rst_restart: cap=%0d trk=%b expected 1 1", captured_cnt_o, tracking_o);
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_errors();
    test_clear();
    test_x_idle();
    test_rst_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d samples never forwarded, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
